// File: rtl/cu_if.sv
// Instruction fetch unit: fetches from instruction memory at pc, hands Cu_IR to decode.
// Optional fetch timeout enabled by defining IF_TIMEOUT_EN.
module cu_if #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        soc_clk,
    input  logic        IFU_reset_n,
    input  logic        fetch_enable,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] Cu_IR,
    output logic        decode_start,
    input  logic        IDU_stall,
    input  logic        IDU_ready,
    input  logic [31:0] pc_increment,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        fetch_error,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;
    localparam logic [1:0] ST_ERROR   = 2'd3;
    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        ds_q, ds_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] next_pc;
    logic [31:0] redir_tgt;
`ifdef IF_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`endif

    // A zero step from decode is treated as a plain 4-byte advance.
    assign next_pc   = pc_q + ((pc_increment == 32'd0) ? 32'd4 : pc_increment);
    assign redir_tgt = redirect_valid ? redirect_pc : pend_pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ds_d      = 1'b0;
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;
`ifdef IF_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (fetch_enable) begin
                    state_d = (pc_q[1:0] != 2'b00) ? ST_ERROR : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    // A redirect seen during the request kills the returning data.
                    if (redirect_valid || pend_v_q) begin
                        pc_d     = redir_tgt;
                        pend_v_d = 1'b0;
                        state_d  = (redir_tgt[1:0] != 2'b00) ? ST_ERROR : ST_REQ;
                    end else begin
                        ir_d    = mem_rdata;
                        ds_d    = 1'b1;
                        state_d = ST_DELIVER;
                    end
                end else begin
                    if (redirect_valid) begin
                        pend_v_d  = 1'b1;
                        pend_pc_d = redirect_pc;
                    end
`ifdef IF_TIMEOUT_EN
                    tmo_d = tmo_q + 32'd1;
                    if (tmo_d == 32'(TIMEOUT_CYCLES)) begin
                        state_d  = ST_ERROR;
                        pend_v_d = 1'b0;
                    end
`endif
                end
            end
            ST_DELIVER: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_IDLE;
                end else if (IDU_ready && !IDU_stall) begin
                    pc_d = next_pc;
                    if (!fetch_enable) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = (next_pc[1:0] != 2'b00) ? ST_ERROR : ST_REQ;
                    end
                end
            end
            default: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_IDLE;
                end
            end
        endcase
`ifdef IF_TIMEOUT_EN
        if (state_d == ST_REQ && (state_q != ST_REQ || mem_ack)) begin
            tmo_d = 32'd0;
        end
`endif
    end

    always_ff @(posedge soc_clk) begin
        if (!IFU_reset_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= NOP_INSN;
            ds_q      <= 1'b0;
            pend_v_q  <= 1'b0;
            pend_pc_q <= 32'd0;
`ifdef IF_TIMEOUT_EN
            tmo_q     <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            ds_q      <= ds_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
`ifdef IF_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign mem_req      = (state_q == ST_REQ);
    assign mem_addr     = mem_req ? pc_q : 32'd0;
    assign Cu_IR        = ir_q;
    assign decode_start = ds_q;
    assign pc           = pc_q;
    assign fetch_error  = (state_q == ST_ERROR);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_cu_if.sv
// Bench for cu_if: directed scenarios plus random traffic, all checked every
// cycle against a transaction-level fetch model.
module tb_cu_if;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int TMO = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        soc_clk = 1'b0;
    logic        IFU_reset_n = 1'b0;
    logic        fetch_enable = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] Cu_IR;
    logic        decode_start;
    logic        IDU_stall = 1'b0;
    logic        IDU_ready = 1'b0;
    logic [31:0] pc_increment = 32'd4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] pc;
    logic        fetch_error;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    cu_if #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
        .soc_clk(soc_clk), .IFU_reset_n(IFU_reset_n), .fetch_enable(fetch_enable),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .Cu_IR(Cu_IR), .decode_start(decode_start), .IDU_stall(IDU_stall),
        .IDU_ready(IDU_ready), .pc_increment(pc_increment),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc),
        .fetch_error(fetch_error), .dbg_state(dbg_state)
    );

    always #5 soc_clk = ~soc_clk;

    // Model: what the fetch unit is doing, in words rather than encodings.
    bit          fetching;    // a memory read is outstanding
    bit          holding;     // an instruction sits with decode
    bit          faulted;     // misaligned or timed out
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    bit          m_pulse;
    bit          kill_v;      // redirect seen while fetching
    logic [31:0] kill_pc;
    int          waited;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit aligned(input logic [31:0] a);
        return (a % 4) == 0;
    endfunction

    task automatic model_edge();
        logic [31:0] step, np;
        bit was_fetching, was_holding, was_faulted;
        was_fetching = fetching;
        was_holding  = holding;
        was_faulted  = faulted;
        m_pulse = 0;
        if (!IFU_reset_n) begin
            fetching = 0; holding = 0; faulted = 0;
            m_pc = RST_PC; m_ir = NOP; kill_v = 0; kill_pc = 0; waited = 0;
            return;
        end
        if (was_fetching) begin
            if (mem_ack) begin
                if (redirect_valid || kill_v) begin
                    np = redirect_valid ? redirect_pc : kill_pc;
                    kill_v = 0;
                    m_pc = np;
                    waited = 0;
                    if (!aligned(np)) begin fetching = 0; faulted = 1; end
                end else begin
                    m_ir = mem_rdata; m_pulse = 1;
                    fetching = 0; holding = 1;
                end
            end else begin
                if (redirect_valid) begin kill_v = 1; kill_pc = redirect_pc; end
`ifdef IF_TIMEOUT_EN
                waited++;
                if (waited == TMO) begin fetching = 0; faulted = 1; kill_v = 0; end
`endif
            end
        end else if (was_holding) begin
            if (redirect_valid) begin
                m_pc = redirect_pc; holding = 0;
            end else if (IDU_ready && !IDU_stall) begin
                step = (pc_increment == 0) ? 32'd4 : pc_increment;
                m_pc = m_pc + step;
                holding = 0;
                if (fetch_enable) begin
                    if (aligned(m_pc)) begin fetching = 1; waited = 0; end
                    else faulted = 1;
                end
            end
        end else if (was_faulted) begin
            if (redirect_valid) begin m_pc = redirect_pc; faulted = 0; end
        end else begin
            if (redirect_valid) m_pc = redirect_pc;
            else if (fetch_enable) begin
                if (aligned(m_pc)) begin fetching = 1; waited = 0; end
                else faulted = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("mem_req", {31'd0, mem_req}, {31'd0, fetching});
        check("mem_addr", mem_addr, fetching ? m_pc : 32'd0);
        check("Cu_IR", Cu_IR, m_ir);
        check("decode_start", {31'd0, decode_start}, {31'd0, m_pulse});
        check("pc", pc, m_pc);
        check("fetch_error", {31'd0, fetch_error}, {31'd0, faulted});
    endtask

    task automatic tick();
        @(posedge soc_clk);
        model_edge();
        @(negedge soc_clk);
        compare_outputs();
    endtask

    int hi;
    int pulses;

    initial begin
        m_pc = RST_PC; m_ir = NOP; kill_pc = 0;
        // Reset
        IFU_reset_n = 1'b0;
        tick(); tick();
        check("rst_pc", pc, RST_PC);
        check("rst_ir", Cu_IR, 32'h0000_0013);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_err", {31'd0, fetch_error}, 32'd0);

        // First fetch, ack one cycle after request
        IFU_reset_n = 1'b1; fetch_enable = 1'b1; IDU_ready = 1'b0;
        tick();
        check("f1_req", {31'd0, mem_req}, 32'd1);
        check("f1_addr", mem_addr, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0010_0093;
        tick();
        mem_ack = 1'b0;
        check("f1_ir", Cu_IR, 32'h0010_0093);
        check("f1_pulse", {31'd0, decode_start}, 32'd1);
        check("f1_pc", pc, 32'd0);
        tick();
        check("f1_pulse_off", {31'd0, decode_start}, 32'd0);

        // Decode stall holds the instruction
        IDU_ready = 1'b1; IDU_stall = 1'b1; pc_increment = 32'd4;
        for (int i = 0; i < 5; i++) tick();
        check("stall_pc", pc, 32'd0);
        check("stall_ir", Cu_IR, 32'h0010_0093);
        IDU_stall = 1'b0;
        tick();
        check("adv_pc", pc, 32'd4);
        check("adv_addr", mem_addr, 32'd4);

        // Redirect while the read is outstanding
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("kill_addr_stable", mem_addr, 32'd4);
        tick(); tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        check("kill_no_pulse", {31'd0, decode_start}, 32'd0);
        check("kill_ir", Cu_IR, 32'h0010_0093);
        check("kill_addr", mem_addr, 32'h100);
        check("model_kill_pc", m_pc, 32'h100);

        // Wrap-around and misaligned redirect
        IDU_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0113;
        tick();
        mem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; IDU_ready = 1'b1; pc_increment = 32'd4;
        tick();
        check("wrap_pc", pc, 32'd0);
        check("model_wrap_pc", m_pc, 32'd0);
        check("wrap_addr0", mem_addr, 32'd0);
        IDU_ready = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("mis_err", {31'd0, fetch_error}, 32'd1);
        check("mis_noreq", {31'd0, mem_req}, 32'd0);
        tick();
        check("mis_err_sticky", {31'd0, fetch_error}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        tick();
        redirect_valid = 1'b0;
        check("err_clear", {31'd0, fetch_error}, 32'd0);
        check("err_clear_pc", pc, 32'd0);

        // Memory never acknowledges
        tick();
        hi = mem_req ? 1 : 0;
`ifdef IF_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin tick(); if (mem_req) hi++; end
        check("tmo_req_cycles", hi, TMO);
        check("tmo_err", {31'd0, fetch_error}, 32'd1);
`else
        for (int i = 0; i < 120; i++) begin tick(); if (mem_req) hi++; end
        check("no_tmo_req_cycles", hi, 121);
        check("no_tmo_err", {31'd0, fetch_error}, 32'd0);
`endif

        // Reset mid-request
        IFU_reset_n = 1'b0;
        tick();
        IFU_reset_n = 1'b1;
        tick();
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        IFU_reset_n = 1'b0;
        tick();
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_pc", pc, RST_PC);
        check("mid_rst_ir", Cu_IR, 32'h0000_0013);
        IFU_reset_n = 1'b1;

        // Random traffic
        pulses = 0;
        for (int i = 0; i < 4000; i++) begin
            IFU_reset_n    = ($urandom_range(0, 299) != 0);
            fetch_enable   = ($urandom_range(0, 7) != 0);
            mem_ack        = ($urandom_range(0, 2) == 0);
            mem_rdata      = $urandom;
            IDU_stall      = ($urandom_range(0, 3) == 0);
            IDU_ready      = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 4))
                0: pc_increment = 32'd0;
                1: pc_increment = 32'd4;
                2: pc_increment = 32'd8;
                3: pc_increment = ($urandom_range(0, 5) == 0) ? 32'd2 : 32'hFFFF_FFF0;
                default: pc_increment = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            endcase
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} |
                             (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
            tick();
            if (decode_start) pulses++;
        end
        n_checks++;
        if (pulses == 0) begin
            n_errors++;
            $display("FAIL random_pulses: got %0d expected >0", pulses);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
